fsm_bit_serializer: RTL and testbench

//   Upstream feeder for the serial pattern-detect Moore FSM: accepts WIDTH-bit words over a

---
 rtl/fsm_ser_pkg.sv | 25 ++
 rtl/fsm_bit_serializer.sv | 157 +++++++++++++++
 tb/tb_fsm_bit_serializer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_ser_pkg.sv
// Shared definitions for the serial pattern-detect path: serializer state
// encoding, detector state encoding and the bit-counter width helper.
package fsm_ser_pkg;

   typedef enum logic [0:0] {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_t;

   // Downstream 1-0-1 detector states, kept here so both ends agree on encoding.
   typedef enum logic [1:0] {
      DET_S0   = 2'd0,
      DET_S1   = 2'd1,
      DET_S10  = 2'd2,
      DET_S101 = 2'd3
   } det_state_t;

   localparam int SER_DEFAULT_WIDTH = 8;

   // Bits needed to count WIDTH-1 down to 0; never narrower than one bit.
   function automatic int ser_cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/fsm_bit_serializer.sv
// Word-to-bit serializer feeding the serial pattern detector's 1-bit input.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts one bit out
// per ser_en cycle; the line idles at IDLE_LEVEL between words.
// Build option: FSM_SER_PREFETCH_EN adds a one-word holding register so
// consecutive words stream with no idle bubble between them.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no word in flight, ser_bit = IDLE_LEVEL, waiting for a word
// ST_SHIFT  | presenting shreg output bit, one bit consumed per ser_en cycle
import fsm_ser_pkg::*;

module fsm_bit_serializer #(
   parameter int   WIDTH      = SER_DEFAULT_WIDTH,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             areset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ser_en,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             word_done
);

   localparam int               CNT_W    = ser_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [0:0]       ST_IDLE  = SER_IDLE;
   localparam logic [0:0]       ST_SHIFT = SER_SHIFT;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] shreg_next;
   logic             accept;
   logic             last_bit;
   logic             out_bit;

`ifdef FSM_SER_PREFETCH_EN
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
`endif

   // Handshake: ready is forced low while reset is asserted.
   always_comb begin
`ifdef FSM_SER_PREFETCH_EN
      in_ready = ~hold_valid_q & ~areset;
`else
      in_ready = (state_q == ST_IDLE) & ~areset;
`endif
      accept   = in_valid & in_ready;
      last_bit = (state_q == ST_SHIFT) & ser_en & (cnt_q == '0);
   end

   // Shift toward the output end so the next bit lands where ser_bit reads.
   always_comb begin
      if (MSB_FIRST) begin
         shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
         out_bit    = shreg_q[WIDTH-1];
      end else begin
         shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
         out_bit    = shreg_q[0];
      end
   end

   // Next-state, shift register, bit counter and (optional) holding register.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
`ifdef FSM_SER_PREFETCH_EN
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A word arriving in idle goes straight to the shifter.
            if (accept) begin
               shreg_d = in_data;
               cnt_d   = CNT_LAST;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ser_en) begin
               if (cnt_q != '0) begin
                  shreg_d = shreg_next;
                  cnt_d   = cnt_q - CNT_ONE;
               end else begin
`ifdef FSM_SER_PREFETCH_EN
                  // Last bit consumed: chain the next word with no gap if one is available.
                  if (hold_valid_q) begin
                     shreg_d      = hold_q;
                     cnt_d        = CNT_LAST;
                     hold_valid_d = 1'b0;
                  end else if (accept) begin
                     shreg_d = in_data;
                     cnt_d   = CNT_LAST;
                  end else begin
                     shreg_d = '0;
                     state_d = ST_IDLE;
                  end
`else
                  shreg_d = '0;
                  state_d = ST_IDLE;
`endif
               end
            end
`ifdef FSM_SER_PREFETCH_EN
            // Words accepted mid-shift wait in the holding register.
            if (accept && !last_bit) begin
               hold_d       = in_data;
               hold_valid_d = 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Registers; reset discards any word in flight.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef FSM_SER_PREFETCH_EN
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef FSM_SER_PREFETCH_EN
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
`endif
      end
   end

   // Serial outputs: the line only carries word data while shifting.
   always_comb begin
      ser_valid = (state_q == ST_SHIFT);
      ser_bit   = ser_valid ? out_bit : IDLE_LEVEL;
      word_done = last_bit;
   end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: an MSB-first instance (idle 0) and an
// LSB-first instance (idle 1) share all inputs.
module tb_fsm_bit_serializer;

   logic       clk = 1'b0;
   logic       areset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       ser_en;
   logic       a_in_ready, a_ser_bit, a_ser_valid, a_word_done;
   logic       b_in_ready, b_ser_bit, b_ser_valid, b_word_done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] data;
      logic [7:0] seq_msb;   // bit 7 = first bit out
      logic [7:0] seq_lsb;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
      .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(a_in_ready), .ser_en(ser_en), .ser_bit(a_ser_bit),
      .ser_valid(a_ser_valid), .word_done(a_word_done)
   );

   fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_b (
      .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(b_in_ready), .ser_en(ser_en), .ser_bit(b_ser_bit),
      .ser_valid(b_ser_valid), .word_done(b_word_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Send one word with ser_en=1 and check both lanes bit by bit.
   task automatic send_word(input logic [7:0] d, input logic [7:0] ea, input logic [7:0] eb);
      in_data  = d;
      in_valid = 1'b1;
      ser_en   = 1'b1;
      @(negedge clk);
      chk("ready_a", a_in_ready, 1);
      chk("ready_b", b_in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("valid_a", a_ser_valid, 1);
         chk("bit_a",   a_ser_bit,   ea[7-k]);
         chk("done_a",  a_word_done, (k == 7));
         chk("valid_b", b_ser_valid, 1);
         chk("bit_b",   b_ser_bit,   eb[7-k]);
         chk("done_b",  b_word_done, (k == 7));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("idle_valid_a", a_ser_valid, 0);
      chk("idle_bit_a",   a_ser_bit,   0);
      chk("idle_valid_b", b_ser_valid, 0);
      chk("idle_bit_b",   b_ser_bit,   1);
      chk("idle_done_a",  a_word_done, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin
      logic [7:0] w1, w2, wf0;
      logic       exp_v [20];
      logic       exp_b [20];
      logic       exp_d [20];
      logic       got_v [20];
      logic       got_b [20];
      logic       got_d [20];
      int         acc2, exp_acc2, dones;
      logic [2:0] win;
      int         nbits, hits, hit_pos;

      vecs[0] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};
      vecs[1] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
      vecs[2] = '{8'hC8, 8'b1100_1000, 8'b0001_0011};
      vecs[3] = '{8'hF0, 8'b1111_0000, 8'b0000_1111};
      vecs[4] = '{8'h6A, 8'b0110_1010, 8'b0101_0110};
      vecs[5] = '{8'h00, 8'b0000_0000, 8'b0000_0000};

      // Reset state
      areset   = 1'b1;
      in_data  = 8'h00;
      in_valid = 1'b0;
      ser_en   = 1'b0;
      #3;
      chk("rst_ready_a", a_in_ready, 0);
      chk("rst_valid_a", a_ser_valid, 0);
      chk("rst_bit_a",   a_ser_bit, 0);
      chk("rst_bit_b",   b_ser_bit, 1);
      chk("rst_done_a",  a_word_done, 0);
      @(posedge clk); #1;
      areset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready_a", a_in_ready, 1);
      chk("post_rst_valid_a", a_ser_valid, 0);
      @(posedge clk); #1;

      // Table of single words, ser_en held high
      for (int i = 0; i < 6; i++)
         send_word(vecs[i].data, vecs[i].seq_msb, vecs[i].seq_lsb);

      // ser_en alternating 0,1: each bit held two cycles, one word_done
      wf0      = 8'hF0;
      in_data  = wf0;
      in_valid = 1'b1;
      ser_en   = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dones    = 0;
      for (int j = 0; j < 17; j++) begin
         ser_en = (j % 2 == 1);
         @(negedge clk);
         if (a_word_done) dones++;
         if (j < 16) begin
            chk("tog_valid_a", a_ser_valid, 1);
            chk("tog_bit_a",   a_ser_bit,   wf0[7 - j/2]);
            chk("tog_bit_b",   b_ser_bit,   wf0[j/2]);
            chk("tog_done_a",  a_word_done, (j == 15));
         end else begin
            chk("tog_end_valid_a", a_ser_valid, 0);
         end
         @(posedge clk); #1;
      end
      chk("tog_done_count", dones, 1);

      // Back-to-back words with in_valid held
      w1       = 8'hAA;
      w2       = 8'h55;
      ser_en   = 1'b1;
      in_data  = w1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready_first", a_in_ready, 1);
      @(posedge clk); #1;
      in_data = w2;
      acc2    = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         got_v[c] = a_ser_valid;
         got_b[c] = a_ser_bit;
         got_d[c] = a_word_done;
         if (in_valid && a_in_ready && acc2 < 0) acc2 = c;
         @(posedge clk); #1;
         if (acc2 == c) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
`ifdef FSM_SER_PREFETCH_EN
         exp_v[c] = (c < 16);
         exp_b[c] = (c < 8) ? w1[7-c] : ((c < 16) ? w2[15-c] : 1'b0);
         exp_d[c] = (c == 7) || (c == 15);
`else
         exp_v[c] = (c < 8) || (c >= 9 && c <= 16);
         exp_b[c] = (c < 8) ? w1[7-c] : ((c >= 9 && c <= 16) ? w2[16-c] : 1'b0);
         exp_d[c] = (c == 7) || (c == 16);
`endif
      end
`ifdef FSM_SER_PREFETCH_EN
      exp_acc2 = 0;
`else
      exp_acc2 = 8;
`endif
      for (int c = 0; c < 20; c++) begin
         chk("b2b_valid", got_v[c], exp_v[c]);
         chk("b2b_bit",   got_b[c], exp_b[c]);
         chk("b2b_done",  got_d[c], exp_d[c]);
      end
      chk("b2b_second_accept_cycle", acc2, exp_acc2);
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("b2b_drain_a", a_ser_valid, 0);
      chk("b2b_drain_b", b_ser_valid, 0);
      @(posedge clk); #1;

      // Reset in the middle of 8'hFF, then 8'h81
      in_data  = 8'hFF;
      in_valid = 1'b1;
      ser_en   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_pre_valid_a", a_ser_valid, 1);
      chk("mid_pre_bit_a",   a_ser_bit, 1);
      areset = 1'b1;
      #1;
      chk("mid_rst_valid_a", a_ser_valid, 0);
      chk("mid_rst_bit_a",   a_ser_bit, 0);
      chk("mid_rst_bit_b",   b_ser_bit, 1);
      chk("mid_rst_done_a",  a_word_done, 0);
      chk("mid_rst_ready_a", a_in_ready, 0);
      @(negedge clk);
      chk("mid_rst_done_b",  b_word_done, 0);
      @(posedge clk); #1;
      areset = 1'b0;
      @(negedge clk);
      chk("mid_rel_ready_a", a_in_ready, 1);
      chk("mid_rel_valid_a", a_ser_valid, 0);
      @(posedge clk); #1;
      send_word(8'h81, 8'b1000_0001, 8'b1000_0001);

      // End-to-end: 1-0-1 seen once in 8'b1010_0000 sent MSB first
      in_data  = 8'b1010_0000;
      in_valid = 1'b1;
      ser_en   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      win      = 3'b000;
      nbits    = 0;
      hits     = 0;
      hit_pos  = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (a_ser_valid && ser_en) begin
            win = {win[1:0], a_ser_bit};
            nbits++;
            if (nbits >= 3 && win == 3'b101) begin
               hits++;
               hit_pos = nbits;
            end
         end
         @(posedge clk); #1;
      end
      chk("e2e_bits",    nbits, 8);
      chk("e2e_hits",    hits, 1);
      chk("e2e_hit_pos", hit_pos, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
